// File: rtl/fifo_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_if_pkg
//  Purpose  : Constants and types shared by the ring-list FIFO, its writers
//             and the read-side stream master.
//  Contents : RD_LATENCY         - cycles from rd_en to rd_val/rd_data
//             DEFAULT_DATA_WIDTH - default FIFO word width
//             rd_state_t         - control state of the read master
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_if_pkg;

    localparam int RD_LATENCY         = 1;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // RUN     : backoff counter is zero, requests follow the request rule
    // BACKOFF : counting down idle cycles after an empty response
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_BACKOFF = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/stream_out_buf.sv
`default_nettype none
// ============================================================================
//  Module   : stream_out_buf
//  Purpose  : Small ring buffer presenting captured FIFO words as a
//             valid/ready stream. No bypass: a pushed word is visible on the
//             next cycle at the earliest.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             push, push_data       - write one word (never issued when full)
//             m_ready               - downstream accept
//             m_valid, m_data       - oldest buffered word
//             occ                   - number of buffered words
//             pop                   - handshake this cycle (m_valid & m_ready)
//  Revision : 1.0 - initial release
// ============================================================================
module stream_out_buf #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 2,
    localparam int OCC_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [OCC_WIDTH-1:0]  occ,
    output logic                  pop
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_head;
    logic [PTR_WIDTH-1:0]  r_tail;
    logic [OCC_WIDTH-1:0]  r_occ;
    logic                  w_pop;

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign m_valid = (r_occ != '0);
    assign w_pop   = m_valid & m_ready;
    assign m_data  = r_mem[r_head];
    assign occ     = r_occ;
    assign pop     = w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (push) begin
                r_tail <= next_ptr(r_tail);
            end
            if (w_pop) begin
                r_head <= next_ptr(r_head);
            end
            case ({push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage carries no reset; contents are only observed while m_valid=1.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_tail] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_stream_reader
//  Purpose  : Read-side master for the ring-list FIFO. Issues rd_en requests,
//             captures the one-cycle-later responses into stream_out_buf and
//             streams them downstream. Backs off POLL_GAP cycles after an
//             empty response before polling again.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             en              - allows new read requests
//             rd_en           - read request to the FIFO
//             rd_data, rd_val - FIFO response (valid only the cycle after rd_en)
//             m_valid, m_data, m_ready - downstream stream
//             word_cnt        - delivered words, wraps modulo 2^CNT_WIDTH
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_if_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 2,
    parameter int POLL_GAP   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_val,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);
    localparam int SUM_WIDTH = OCC_WIDTH + 1;
    localparam int GAP_WIDTH = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    rd_state_t              r_state;
    rd_state_t              w_state_nxt;
    logic [GAP_WIDTH-1:0]   r_gap_cnt;
    logic [GAP_WIDTH-1:0]   w_gap_nxt;
    logic                   r_pend;
    logic [CNT_WIDTH-1:0]   r_word_cnt;

    logic                   w_push;
    logic                   w_empty_rsp;
    logic                   w_pop;
    logic                   w_space;
    logic [OCC_WIDTH-1:0]   w_occ;
    logic [SUM_WIDTH-1:0]   w_committed;

    // r_pend marks the single cycle (RD_LATENCY=1) in which rd_val/rd_data
    // are fresh; in every other cycle they are stale and ignored.
    assign w_push      = r_pend & rd_val;
    assign w_empty_rsp = r_pend & ~rd_val;

    // Words already buffered plus the one in flight, less the one leaving
    // this cycle. Keeping this below BUF_DEPTH means a push never meets a
    // full buffer. pop <= occ, so the sum never goes negative.
    assign w_committed = SUM_WIDTH'(w_occ) + SUM_WIDTH'(r_pend) - SUM_WIDTH'(w_pop);
    assign w_space     = (w_committed < SUM_WIDTH'(BUF_DEPTH));

    // An empty response in this cycle already counts as the start of the
    // backoff: no request is issued in the response cycle itself, which
    // spaces empty polls POLL_GAP+2 cycles apart.
    assign rd_en = ~reset & en & (r_state == ST_RUN) & ~w_empty_rsp & w_space;

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_empty_rsp && (POLL_GAP > 0)) begin
                    w_state_nxt = ST_BACKOFF;
                    w_gap_nxt   = GAP_WIDTH'(POLL_GAP);
                end
            end
            ST_BACKOFF: begin
                w_gap_nxt = r_gap_cnt - 1'b1;
                if (r_gap_cnt == GAP_WIDTH'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_gap_cnt  <= '0;
            r_pend     <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_pend    <= rd_en;
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign word_cnt = r_word_cnt;

    stream_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (rd_data),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .occ       (w_occ),
        .pop       (w_pop)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_stream_reader
//  Purpose  : Self-checking bench for fifo_stream_reader. A queue stands in
//             for the FIFO; a word-level model tracks the words in flight and
//             buffered, the delivered count and the backoff window.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 3;
    localparam int GAP   = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_val;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [CW-1:0] word_cnt;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (DEPTH),
        .POLL_GAP   (GAP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_val   (rd_val),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .word_cnt (word_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] bufq   [$];
    int            delivered;
    int            last_empty;
    int            cyc;
    logic          pend_m;

    // Values sampled in the most recent tick
    logic          s_rd_en;
    logic          s_valid;
    logic          s_hs;
    logic [DW-1:0] s_data;

    int t0, first_rd, first_val, first_hs, last_hs, nd, prev, lat, nreq, nhs;
    logic found, reached;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model
    // at the rising edge, then let the FIFO stand-in answer a request.
    task automatic tick();
        int   occ;
        logic exp_valid;
        logic pop_m;
        logic exp_rd;
        @(negedge clk);
        occ       = bufq.size();
        exp_valid = (occ != 0);
        pop_m     = exp_valid && m_ready;
        exp_rd    = !reset && en && ((cyc - last_empty) > GAP) && !(pend_m && !rd_val)
                    && ((occ + int'(pend_m) - int'(pop_m)) < DEPTH);
        s_rd_en = rd_en;
        s_valid = m_valid;
        s_data  = m_data;
        s_hs    = m_valid & m_ready;
        chk("rd_en", 32'(rd_en), 32'(exp_rd));
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        if (exp_valid) chk("m_data", 32'(m_data), 32'(bufq[0]));
        chk("word_cnt", 32'(word_cnt), delivered % (1 << CW));
        @(posedge clk);
        if (reset) begin
            bufq.delete();
            delivered  = 0;
            pend_m     = 1'b0;
            last_empty = -1000;
        end else begin
            if (pop_m) begin
                void'(bufq.pop_front());
                delivered++;
            end
            if (pend_m && rd_val) bufq.push_back(rd_data);
            if (pend_m && !rd_val) last_empty = cyc;
            pend_m = s_rd_en;
        end
        #1;
        if (s_rd_en) begin
            if (fifo_q.size() != 0) begin
                rd_val  = 1'b1;
                rd_data = fifo_q.pop_front();
            end else begin
                rd_val = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b0;
        m_ready    = 1'b0;
        rd_val     = 1'b0;
        rd_data    = '0;
        cyc        = 0;
        delivered  = 0;
        last_empty = -1000;
        pend_m     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        reset = 1'b0;

        // Burst drain
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h11 + i));
        en = 1'b1; m_ready = 1'b1;
        first_rd = -1; first_val = -1; first_hs = -1; last_hs = -1; nd = 0;
        for (int i = 0; i < 20; i++) begin
            t0 = cyc;
            tick();
            if (s_rd_en && first_rd < 0) first_rd = t0;
            if (s_valid && first_val < 0) first_val = t0;
            if (s_hs) begin
                chk("burst_data", 32'(s_data), 32'(8'h11 + nd));
                if (nd == 0) first_hs = t0;
                last_hs = t0;
                nd++;
            end
        end
        chk("burst_latency", first_val - first_rd, 2);
        chk("burst_count", nd, 8);
        chk("burst_back_to_back", last_hs - first_hs, 7);
        chk("burst_word_cnt", 32'(word_cnt), 8);

        // Empty backoff
        prev = -1;
        for (int i = 0; i < 30; i++) begin
            t0 = cyc;
            tick();
            if (s_rd_en) begin
                if (prev >= 0) chk("poll_spacing", t0 - prev, GAP + 2);
                prev = t0;
            end
        end
        t0 = cyc;
        fifo_q.push_back(8'hA5);
        found = 1'b0; lat = 99;
        for (int i = 0; i < 12; i++) begin
            if (!found) begin
                prev = cyc;
                tick();
                if (s_valid && s_data == 8'hA5) begin
                    found = 1'b1;
                    lat   = prev - t0;
                end
            end
        end
        chk("a5_seen", 32'(found), 1);
        chk("a5_latency_le8", 32'(lat <= 8), 1);

        // Stale rd_val
        en = 1'b0;
        do_reset();
        rd_val = 1'b1; rd_data = 8'h55; m_ready = 1'b1;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_rd_en) nreq++;
        end
        chk("stale_no_req", nreq, 0);
        chk("stale_m_valid", 32'(m_valid), 0);
        chk("stale_word_cnt", 32'(word_cnt), 0);

        // Backpressure
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h60 + i));
        en = 1'b1; m_ready = 1'b0; nreq = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_rd_en) nreq++;
            if (s_valid) chk("bp_hold", 32'(s_data), 32'h60);
        end
        chk("bp_requests", nreq, DEPTH);
        m_ready = 1'b1; nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (nd < 6) begin
                tick();
                if (s_hs) begin
                    chk("bp_order", 32'(s_data), 32'(8'h60 + nd));
                    nd++;
                end
            end
        end
        chk("bp_count", nd, 6);

        // Reset mid-transfer
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h70 + i));
        m_ready = 1'b0; reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!reached) begin
                tick();
                if (bufq.size() == 2 && pend_m) reached = 1'b1;
            end
        end
        chk("rmt_reached", 32'(reached), 1);
        do_reset();
        en = 1'b0;
        tick();
        chk("rmt_m_valid", 32'(s_valid), 0);
        chk("rmt_word_cnt", 32'(word_cnt), 0);
        tick();
        chk("rmt_no_capture", 32'(s_valid), 0);

        // Throttled consumer, word_cnt wraps past 2^CW
        for (int i = 0; i < 40; i++) fifo_q.push_back(8'($urandom));
        en = 1'b1; nhs = 0;
        for (int i = 0; i < 60; i++) begin
            m_ready = ((i % 2) == 0);
            tick();
            if (i >= 10 && i < 50 && s_hs) nhs++;
        end
        chk("throttle_half", nhs, 20);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            en      = (($urandom % 8) != 0);
            m_ready = (($urandom % 4) != 0);
            if ((($urandom % 2) == 1) && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
            reset   = (($urandom % 300) == 0);
            tick();
        end
        reset = 1'b0; en = 1'b0; m_ready = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
